// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants: data width, reset PC, NOP encoding,
// fetch FSM state encodings and the fetch-PC mux select.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_INC      = 2'd1,
        PC_REDIRECT = 2'd2,
        PC_STORED   = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch PC register, next-PC mux (+4 / redirect / stored target) and the
// deferred-redirect target with its pending flag.
module fetch_pc_gen #(
    parameter logic [riscv_pkg::XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  riscv_pkg::pc_sel_e         pc_sel,
    input  logic [riscv_pkg::XLEN-1:0] redirect_target,
    input  logic                       store_redirect,
    input  logic                       clear_pending,
    output logic [riscv_pkg::XLEN-1:0] pc,
    output logic                       redirect_pending
);
    import riscv_pkg::*;

    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] stored_target;

    // Next-PC select; +4 wraps naturally at 2^32.
    always_comb begin
        pc_next = pc;
        case (pc_sel)
            PC_INC:      pc_next = pc + XLEN'(4);
            PC_REDIRECT: pc_next = redirect_target;
            PC_STORED:   pc_next = stored_target;
            default:     pc_next = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc               <= RESET_PC;
            stored_target    <= '0;
            redirect_pending <= 1'b0;
        end else begin
            pc <= pc_next;
            if (store_redirect) begin
                stored_target    <= redirect_target;
                redirect_pending <= 1'b1;
            end else if (clear_pending) begin
                redirect_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: single-outstanding imem handshake feeding IF/ID.
// Optional misaligned-redirect pulse enabled by FETCH_MISALIGN_CHECK_EN.
module instruction_fetch_unit #(
    parameter logic [riscv_pkg::XLEN-1:0] RESET_PC  = riscv_pkg::RESET_PC,
    parameter logic [riscv_pkg::XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       stall,
    input  logic                       redirect_valid,
    input  logic [riscv_pkg::XLEN-1:0] redirect_pc,
    output logic                       imem_req,
    output logic [riscv_pkg::XLEN-1:0] imem_addr,
    input  logic                       imem_ack,
    input  logic [riscv_pkg::XLEN-1:0] imem_rdata,
    output logic [riscv_pkg::XLEN-1:0] pc_out,
    output logic [riscv_pkg::XLEN-1:0] instruction_out,
    output logic                       fetch_valid,
    output logic                       misalign_fault
);
    import riscv_pkg::*;

    logic [1:0]      state;
    logic [1:0]      state_n;
    logic            fetch_valid_n;
    logic [XLEN-1:0] pc_out_n;
    logic [XLEN-1:0] instruction_n;
    logic [XLEN-1:0] pend_pc;
    logic [XLEN-1:0] pend_pc_n;
    logic [XLEN-1:0] pend_instr;
    logic [XLEN-1:0] pend_instr_n;
    logic            misalign_n;
    logic            slot_free;

    pc_sel_e         pc_sel;
    logic            store_redirect;
    logic            clear_pending;
    logic [XLEN-1:0] fetch_pc;
    logic            redirect_pending;
    logic [XLEN-1:0] redirect_target;

    // Targets are always word-aligned; low bits are masked off.
    assign redirect_target = redirect_pc & ~XLEN'(3);
    assign imem_addr       = fetch_pc;

    fetch_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk              (clk),
        .reset_n          (reset_n),
        .pc_sel           (pc_sel),
        .redirect_target  (redirect_target),
        .store_redirect   (store_redirect),
        .clear_pending    (clear_pending),
        .pc               (fetch_pc),
        .redirect_pending (redirect_pending)
    );

    // Next-state and output decode.
    always_comb begin
        state_n        = state;
        fetch_valid_n  = fetch_valid;
        pc_out_n       = pc_out;
        instruction_n  = instruction_out;
        pend_pc_n      = pend_pc;
        pend_instr_n   = pend_instr;
        pc_sel         = PC_HOLD;
        store_redirect = 1'b0;
        clear_pending  = 1'b0;
        misalign_n     = 1'b0;
        slot_free      = !fetch_valid || !stall;

        if (fetch_valid && !stall) begin
            fetch_valid_n = 1'b0;
            instruction_n = NOP_INSTR;
        end

`ifdef FETCH_MISALIGN_CHECK_EN
        misalign_n = redirect_valid && (redirect_pc[1:0] != 2'b00);
`endif

        if (redirect_valid) begin
            fetch_valid_n = 1'b0;
            instruction_n = NOP_INSTR;
            pend_pc_n     = '0;
            pend_instr_n  = NOP_INSTR;
            state_n       = ST_REQ;
            // An outstanding request must finish at its original address.
            if (state == ST_REQ && !imem_ack) begin
                store_redirect = 1'b1;
            end else begin
                pc_sel        = PC_REDIRECT;
                clear_pending = 1'b1;
            end
        end else begin
            case (state)
                ST_IDLE: state_n = ST_REQ;
                ST_REQ: begin
                    if (imem_ack) begin
                        if (redirect_pending) begin
                            pc_sel        = PC_STORED;
                            clear_pending = 1'b1;
                        end else if (slot_free) begin
                            fetch_valid_n = 1'b1;
                            pc_out_n      = fetch_pc;
                            instruction_n = imem_rdata;
                            pc_sel        = PC_INC;
                        end else begin
                            pend_pc_n    = fetch_pc;
                            pend_instr_n = imem_rdata;
                            pc_sel       = PC_INC;
                            state_n      = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        fetch_valid_n = 1'b1;
                        pc_out_n      = pend_pc;
                        instruction_n = pend_instr;
                        state_n       = ST_REQ;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            imem_req        <= 1'b0;
            fetch_valid     <= 1'b0;
            pc_out          <= '0;
            instruction_out <= NOP_INSTR;
            pend_pc         <= '0;
            pend_instr      <= NOP_INSTR;
            misalign_fault  <= 1'b0;
        end else begin
            state           <= state_n;
            imem_req        <= (state_n == ST_REQ);
            fetch_valid     <= fetch_valid_n;
            pc_out          <= pc_out_n;
            instruction_out <= instruction_n;
            pend_pc         <= pend_pc_n;
            pend_instr      <= pend_instr_n;
            misalign_fault  <= misalign_n;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory returns {16'hC0DE, addr[15:0]}.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        fetch_valid;
    logic        misalign_fault;

    int checks = 0;
    int errors = 0;
    logic exp_misalign;

    always #5 clk = ~clk;

    assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

    instruction_fetch_unit dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .fetch_valid     (fetch_valid),
        .misalign_fault  (misalign_fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic fv, input logic [31:0] pc, input logic [31:0] instr);
        check({tag, ".req"},   {31'd0, imem_req},    {31'd0, req});
        check({tag, ".addr"},  imem_addr,            addr);
        check({tag, ".fv"},    {31'd0, fetch_valid}, {31'd0, fv});
        check({tag, ".pc"},    pc_out,               pc);
        check({tag, ".instr"}, instruction_out,      instr);
    endtask

    initial begin
`ifdef FETCH_MISALIGN_CHECK_EN
        exp_misalign = 1'b1;
`else
        exp_misalign = 1'b0;
`endif
        // Reset with ack held high; it must be ignored through reset and IDLE.
        imem_ack = 1'b1;
        step(); step();
        chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
        check("reset.misalign", {31'd0, misalign_fault}, 32'd0);
        reset_n = 1'b1;
        step();
        chk_out("idle2req", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
        step();
        chk_out("stream0", 1'b1, 32'h4, 1'b1, 32'h0, 32'hC0DE_0000);
        step();
        chk_out("stream1", 1'b1, 32'h8, 1'b1, 32'h4, 32'hC0DE_0004);

        // Stall: one word parked in HOLD, outputs frozen.
        stall = 1'b1;
        step();
        chk_out("hold0", 1'b0, 32'hC, 1'b1, 32'h4, 32'hC0DE_0004);
        step();
        chk_out("hold1", 1'b0, 32'hC, 1'b1, 32'h4, 32'hC0DE_0004);
        step();
        chk_out("hold2", 1'b0, 32'hC, 1'b1, 32'h4, 32'hC0DE_0004);
        stall = 1'b0;
        step();
        chk_out("unhold", 1'b1, 32'hC, 1'b1, 32'h8, 32'hC0DE_0008);
        step();
        chk_out("resume", 1'b1, 32'h10, 1'b1, 32'hC, 32'hC0DE_000C);

        // Redirect coinciding with ack: data dropped.
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        chk_out("redir_ack", 1'b1, 32'h200, 1'b0, 32'hC, NOP);
        redirect_valid = 1'b0;
        step();
        chk_out("after_redir", 1'b1, 32'h204, 1'b1, 32'h200, 32'hC0DE_0200);
        imem_ack = 1'b0;
        step();
        chk_out("consume", 1'b1, 32'h204, 1'b0, 32'h200, NOP);

        // Redirect while a request to 0x20 waits for its ack.
        imem_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h20;
        step();
        check("to20.addr", imem_addr, 32'h20);
        imem_ack = 1'b0; redirect_pc = 32'h100;
        step();
        chk_out("wait0", 1'b1, 32'h20, 1'b0, 32'h200, NOP);
        redirect_valid = 1'b0;
        step();
        chk_out("wait1", 1'b1, 32'h20, 1'b0, 32'h200, NOP);
        imem_ack = 1'b1;
        step();
        chk_out("drop20", 1'b1, 32'h100, 1'b0, 32'h200, NOP);
        step();
        chk_out("fetch100", 1'b1, 32'h104, 1'b1, 32'h100, 32'hC0DE_0100);

        // Newer deferred redirect overwrites the stored target.
        imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
        step();
        chk_out("defer300", 1'b1, 32'h104, 1'b0, 32'h100, NOP);
        redirect_pc = 32'h340;
        step();
        check("defer340.addr", imem_addr, 32'h104);
        redirect_valid = 1'b0; imem_ack = 1'b1;
        step();
        chk_out("use340", 1'b1, 32'h340, 1'b0, 32'h100, NOP);

        // Misaligned target.
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        step();
        check("mis.addr", imem_addr, 32'h100);
        check("mis.pulse", {31'd0, misalign_fault}, {31'd0, exp_misalign});
        redirect_valid = 1'b0;
        step();
        check("mis.clear", {31'd0, misalign_fault}, 32'd0);
        chk_out("mis.fetch", 1'b1, 32'h104, 1'b1, 32'h100, 32'hC0DE_0100);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        check("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        step();
        chk_out("wrap", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hC0DE_FFFC);
        step();
        chk_out("wrap1", 1'b1, 32'h4, 1'b1, 32'h0, 32'hC0DE_0000);

        // Reset with a request outstanding; late ack ignored.
        imem_ack = 1'b0;
        step();
        chk_out("outstanding", 1'b1, 32'h4, 1'b0, 32'h0, NOP);
        reset_n = 1'b0;
        step();
        chk_out("midreset", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
        reset_n = 1'b1; imem_ack = 1'b1;
        step();
        chk_out("lateack", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
        step();
        chk_out("restart", 1'b1, 32'h4, 1'b1, 32'h0, 32'hC0DE_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
